// File: rtl/apb_pkg.sv
// Shared APB definitions used by the requester (apb_top) and the completer side.
package apb_pkg;

    localparam int APB_ADDR_W = 9;
    localparam int APB_DATA_W = 8;
    localparam int APB_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_regfile_mem.sv
// Byte-wide register file with a synchronous write port, an asynchronous read port and clear-on-reset.
module apb_regfile_mem #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              raddr_ok;

    // Every byte must clear on reset, so the array lives in fabric flops rather than RAM.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign raddr_ok = ({1'b0, raddr} < (AW + 1)'(DEPTH));
    assign rdata    = raddr_ok ? mem_q[raddr] : '0;

endmodule

// File: rtl/apb_completer.sv
// APB completer: register file behind a psel line with programmable wait states and
// out-of-range error response. All outputs are registered.
module apb_completer
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int                     MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [APB_CNT_W-1:0]   WAIT_LOAD = APB_CNT_W'(WAIT_CYCLES);

    apb_state_e          state_q, state_d;
    logic [APB_CNT_W-1:0] cnt_q, cnt_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;

    logic                setup, active, addr_err;
    logic                enter_resp, resp_err, resp_write;
    logic                mem_we;
    logic [MEM_AW-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;

    assign setup    = psel & ~penable;
    assign active   = psel & penable;
    assign addr_err = ({1'b0, paddr} >= (ADDR_W + 1)'(DEPTH));

    // With zero wait states the read happens on the setup edge, before the address is latched.
    assign rd_addr = (state_q == ST_IDLE) ? paddr[MEM_AW-1:0] : addr_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        prdata_d   = prdata_q;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        enter_resp = 1'b0;
        resp_err   = 1'b0;
        resp_write = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    addr_d  = paddr[MEM_AW-1:0];
                    write_d = pwrite;
                    wdata_d = pwdata;
                    err_d   = addr_err;
                    if (WAIT_CYCLES > 0) begin
                        cnt_d   = WAIT_LOAD;
                        state_d = ST_WAIT;
                    end else begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                        resp_err   = addr_err;
                        resp_write = pwrite;
                    end
                end
            end
            ST_WAIT: begin
                if (!active) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == APB_CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    cnt_d      = '0;
                    enter_resp = 1'b1;
                    resp_err   = err_q;
                    resp_write = write_q;
                end else begin
                    cnt_d = cnt_q - APB_CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                mem_we  = active & write_q & ~err_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            pready_d  = 1'b1;
            pslverr_d = resp_err;
            if (!resp_write) begin
                prdata_d = resp_err ? '0 : rd_data;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (presetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    apb_regfile_mem #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .AW    (MEM_AW)
    ) u_mem (
        .clk  (pclk),
        .srst (presetn),
        .we   (mem_we),
        .waddr(addr_q),
        .wdata(wdata_q),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule
